// File: rtl/fetch_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_if
//   Handshake and control bundle between fetch, the fetch_queue and decode.
//
//   Parameters
//     WIDTH  instruction word width
//     OPW    opcode field width (top OPW bits of a word)
//     DEPTH  queue entries; sets the width of count
//
//   Signals (direction seen from the queue, i.e. the slave modport)
//     in_valid/in_data/in_ready     fetch -> queue word handshake
//     out_valid/out_data/out_ready  queue -> decode word handshake
//     flush                         discard queued words, abort injection
//     req_call/req_ret/req_rti      one-cycle micro-op injection requests
//     inj_imm                       low field of the CALL micro-op
//     seq_busy                      injection sequencer is active
//     count                         number of queued words
// ---------------------------------------------------------------------------
interface fetch_queue_if #(
  parameter int WIDTH = 48,
  parameter int OPW   = 16,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                 in_valid;
  logic [WIDTH-1:0]     in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic                 out_ready;
  logic                 flush;
  logic                 req_call;
  logic                 req_ret;
  logic                 req_rti;
  logic [WIDTH-OPW-1:0] inj_imm;
  logic                 seq_busy;
  logic [CW-1:0]        count;

  // The queue itself.
  modport slave (
    input  in_valid, in_data, out_ready, flush,
    input  req_call, req_ret, req_rti, inj_imm,
    output in_ready, out_valid, out_data, seq_busy, count
  );

  // The surrounding pipeline (fetch + decode + branch control).
  modport master (
    output in_valid, in_data, out_ready, flush,
    output req_call, req_ret, req_rti, inj_imm,
    input  in_ready, out_valid, out_data, seq_busy, count
  );
endinterface

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   IF/ID instruction buffer. A DEPTH-entry circular FIFO of fetched words
//   plus an injection sequencer that places micro-op words on the decode
//   side ahead of anything queued:
//     CALL -> {OP_PUSH_PC_HIGH, imm}
//     RET  -> {OP_POP_PC_LOW,   0}
//     RTI  -> {OP_POP_PC_LOW,   0}, then {OP_POP_FLAGS, 0}
//   While an injection is in progress the queue holds its head but keeps
//   accepting pushes. flush empties the queue and aborts any injection.
//
//   Ports
//     clk    rising-edge clock
//     reset  asynchronous, active-low; clears pointers, count, sequencer
//     bus    fetch_queue_if.slave (handshakes, flush, requests, status)
//
//   Build option
//     FETCH_QUEUE_BYPASS_EN  when defined, an empty idle queue forwards
//                            in_data straight to out_data if decode is
//                            ready, without writing it into the buffer.
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int             WIDTH           = 48,
  parameter int             OPW             = 16,
  parameter int             DEPTH           = 4,
  parameter logic [OPW-1:0] OP_PUSH_PC_HIGH = 16'hB000,
  parameter logic [OPW-1:0] OP_POP_PC_LOW   = 16'hB800,
  parameter logic [OPW-1:0] OP_POP_FLAGS    = 16'h7800
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  bus
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int IMW = WIDTH - OPW;

  typedef enum logic [1:0] {S_IDLE, S_INJ1, S_INJ2} state_t;
  typedef enum logic [1:0] {K_CALL, K_RET, K_RTI}   kind_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  state_t           r_state,  w_state_nxt;
  kind_t            r_kind,   w_kind_nxt;
  logic [IMW-1:0]   r_imm,    w_imm_nxt;

  logic             w_seq_busy;
  logic             w_in_ready;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_inj_word;
  logic             w_out_valid;
  logic [WIDTH-1:0] w_out_data;

  // -------------------------------------------------------------------------
  // Handshake qualifiers
  // -------------------------------------------------------------------------
  assign w_seq_busy = (r_state != S_IDLE);
  // Full only at count==DEPTH, so a same-cycle pop never frees a slot early.
  assign w_in_ready = (r_count != CW'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = (r_count == '0) && !w_seq_busy && bus.in_valid && bus.out_ready;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed word is consumed directly and never enters the buffer.
  assign w_push = bus.in_valid && w_in_ready && !w_bypass;
  // The queue head is frozen while the sequencer owns the output.
  assign w_pop  = bus.out_ready && (r_count != '0) && !w_seq_busy;

  // -------------------------------------------------------------------------
  // Queue pointers and occupancy
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so natural overflow gives the wrap.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; its contents are only observed
  // through rd_ptr when count says they were written, so clearing it would
  // only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push && !bus.flush) r_mem[r_wr_ptr] <= bus.in_data;
  end

  // -------------------------------------------------------------------------
  // Injection sequencer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_kind  <= K_CALL;
      r_imm   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_kind  <= w_kind_nxt;
      r_imm   <= w_imm_nxt;
    end
  end

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that skips an assignment would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_kind_nxt  = r_kind;
    w_imm_nxt   = r_imm;
    case (r_state)
      S_IDLE: begin
        // Highest-priority request wins; the others are dropped.
        if (bus.req_rti) begin
          w_state_nxt = S_INJ1;
          w_kind_nxt  = K_RTI;
        end else if (bus.req_ret) begin
          w_state_nxt = S_INJ1;
          w_kind_nxt  = K_RET;
        end else if (bus.req_call) begin
          w_state_nxt = S_INJ1;
          w_kind_nxt  = K_CALL;
          w_imm_nxt   = bus.inj_imm;
        end
      end
      S_INJ1: begin
        if (bus.out_ready) w_state_nxt = (r_kind == K_RTI) ? S_INJ2 : S_IDLE;
      end
      S_INJ2: begin
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.flush) w_state_nxt = S_IDLE;
  end

  always_comb begin
    w_inj_word = '0;
    case (r_state)
      S_INJ1: begin
        if (r_kind == K_CALL) w_inj_word = {OP_PUSH_PC_HIGH, r_imm};
        else                  w_inj_word = {OP_POP_PC_LOW, {IMW{1'b0}}};
      end
      S_INJ2:  w_inj_word = {OP_POP_FLAGS, {IMW{1'b0}}};
      default: w_inj_word = '0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output select: sequencer word, bypassed word, or queue head
  // -------------------------------------------------------------------------
  always_comb begin
    w_out_valid = 1'b0;
    w_out_data  = '0;
    if (w_seq_busy) begin
      w_out_valid = 1'b1;
      w_out_data  = w_inj_word;
    end else if (w_bypass) begin
      w_out_valid = 1'b1;
      w_out_data  = bus.in_data;
    end else if (r_count != '0) begin
      w_out_valid = 1'b1;
      w_out_data  = r_mem[r_rd_ptr];
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_data;
  assign bus.seq_busy  = w_seq_busy;
  assign bus.count     = r_count;

endmodule
